// File: rtl/booth_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, one iteration per clock.
// SIGNED=1 uses radix-2 Booth recoding; SIGNED=0 uses plain shift-add.
// Z[2W-1:W] feeds HI, Z[W-1:0] feeds LO.
module booth_multiplier #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Z
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             qm1_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last_iter;

    assign last_iter = (cnt == CW'(WIDTH - 1));

    // One iteration: add/subtract M into A, then shift {A, Q, q_-1} right by one
    always_comb begin
        sum = a_reg;
        if (SIGNED) begin
            case ({q_reg[0], qm1_reg})
                2'b01:   sum = a_reg + m_reg;
                2'b10:   sum = a_reg - m_reg;
                default: sum = a_reg;
            endcase
            a_nxt = {sum[WIDTH], sum[WIDTH:1]};
        end else begin
            if (q_reg[0]) sum = a_reg + m_reg;
            a_nxt = {1'b0, sum[WIDTH:1]};
        end
        q_nxt = {sum[0], q_reg[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = BUSY;
            BUSY: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and product register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            qm1_reg <= 1'b0;
            cnt     <= '0;
            Z       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    m_reg   <= SIGNED ? {multiplicand[WIDTH-1], multiplicand}
                                      : {1'b0, multiplicand};
                    a_reg   <= '0;
                    q_reg   <= multiplier;
                    qm1_reg <= 1'b0;
                    cnt     <= '0;
                end
                BUSY: begin
                    a_reg   <= a_nxt;
                    q_reg   <= q_nxt;
                    qm1_reg <= q_reg[0];
                    cnt     <= cnt + 1'b1;
                    if (last_iter) Z <= {a_nxt[WIDTH-1:0], q_nxt};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench: drivers push expected products, monitors pop on done.
module tb_booth_multiplier;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_s = 1'b0, start_u = 1'b0;
    logic [W-1:0]  mcand = '0, mplier = '0;
    logic          busy_s, done_s, busy_u, done_u;
    logic [2*W-1:0] z_s, z_u;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_s[$];
    logic [63:0] exp_u[$];
    logic [63:0] last_s, last_u;
    int run_s = 0, run_u = 0;

    always #5 clk = ~clk;

    booth_multiplier #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .start(start_s),
        .multiplicand(mcand), .multiplier(mplier),
        .busy(busy_s), .done(done_s), .Z(z_s)
    );

    booth_multiplier #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .start(start_u),
        .multiplicand(mcand), .multiplier(mplier),
        .busy(busy_u), .done(done_u), .Z(z_u)
    );

    function automatic logic [63:0] ref_s(input logic [31:0] m, input logic [31:0] q);
        longint p;
        p = longint'($signed(m)) * longint'($signed(q));
        return 64'(p);
    endfunction

    function automatic logic [63:0] ref_u(input logic [31:0] m, input logic [31:0] q);
        logic [63:0] a, b;
        a = {32'b0, m};
        b = {32'b0, q};
        return a * b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Signed monitor: compare product, busy-low and busy run length on each done
    always @(negedge clk) begin
        if (reset) run_s = 0;
        else begin
            if (busy_s) run_s++;
            if (done_s) begin
                if (exp_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_s: got done=1 expected no done, Z=%h", z_s);
                end else begin
                    check("product_s", z_s, exp_s.pop_front());
                    check("busy_in_done_s", 64'(busy_s), 64'd0);
                    check("latency_s", 64'(run_s), 64'(W));
                end
                run_s = 0;
            end
        end
    end

    // Unsigned monitor
    always @(negedge clk) begin
        if (reset) run_u = 0;
        else begin
            if (busy_u) run_u++;
            if (done_u) begin
                if (exp_u.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_u: got done=1 expected no done, Z=%h", z_u);
                end else begin
                    check("product_u", z_u, exp_u.pop_front());
                    check("busy_in_done_u", 64'(busy_u), 64'd0);
                    check("latency_u", 64'(run_u), 64'(W));
                end
                run_u = 0;
            end
        end
    end

    task automatic issue(input bit sgn, input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] expv);
        @(posedge clk); #1;
        mcand = m; mplier = q;
        if (sgn) begin start_s = 1'b1; exp_s.push_back(expv); last_s = expv; end
        else     begin start_u = 1'b1; exp_u.push_back(expv); last_u = expv; end
        @(posedge clk); #1;
        start_s = 1'b0; start_u = 1'b0;
        mcand = $urandom; mplier = $urandom;
    endtask

    task automatic wait_drain(input bit sgn);
        int n;
        n = 0;
        while ((sgn ? exp_s.size() : exp_u.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL timeout_%0s: got no done within 200 cycles expected done", sgn ? "s" : "u");
            if (sgn) exp_s.delete(); else exp_u.delete();
        end
    endtask

    initial begin
        logic [31:0] m, q;

        // Reset state
        #2 reset = 1'b1;
        #20 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy_s), 64'd0);
        check("reset_done", 64'(done_s), 64'd0);
        check("reset_z_s", z_s, 64'd0);
        check("reset_z_u", z_u, 64'd0);

        // Directed signed cases
        issue(1'b1, 32'd3, 32'd5, 64'h0000_0000_0000_000F);               wait_drain(1'b1);
        issue(1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);       wait_drain(1'b1);
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000); wait_drain(1'b1);
        issue(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000); wait_drain(1'b1);

        // Directed unsigned cases
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001); wait_drain(1'b0);
        issue(1'b0, 32'd0, 32'h1234_5678, 64'd0);                          wait_drain(1'b0);

        // Ignored start during BUSY, then back-to-back start on the cycle after done
        issue(1'b1, 32'd2, 32'd2, 64'd4);
        repeat (8) @(posedge clk);
        #1 mcand = 32'd9; mplier = 32'd9; start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        wait_drain(1'b1);
        issue(1'b1, 32'd9, 32'd9, 64'd81);
        wait_drain(1'b1);

        // Asynchronous reset mid-operation
        issue(1'b1, 32'd100, 32'd100, 64'd10000);
        repeat (14) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy_s), 64'd0);
        check("abort_done", 64'(done_s), 64'd0);
        check("abort_z", z_s, 64'd0);
        exp_s.delete();
        #7 reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_z_after", z_s, 64'd0);
        issue(1'b1, 32'd10, 32'd10, 64'd100);
        wait_drain(1'b1);

        // Hold: operands toggle without start
        repeat (50) begin
            @(posedge clk); #1 mcand = $urandom; mplier = $urandom;
        end
        @(negedge clk);
        check("hold_z", z_s, last_s);
        check("hold_done", 64'(done_s), 64'd0);

        // Randomized against the arithmetic reference
        for (int i = 0; i < 20; i++) begin
            m = $urandom; q = $urandom;
            if (i == 0) m = 32'h7FFF_FFFF;
            if (i == 1) q = 32'h8000_0000;
            issue(1'b1, m, q, ref_s(m, q));
            wait_drain(1'b1);
            m = $urandom; q = $urandom;
            issue(1'b0, m, q, ref_u(m, q));
            wait_drain(1'b0);
        end
        check("final_z_u", z_u, last_u);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
